// File: rtl/rs_custom_pkg.sv
// Shared types and helpers for the custom-unit reservation station.
// Width constants carry the values of the shared constants header.
package rs_custom_pkg;

  localparam int DATA_LEN     = 32;
  localparam int RRF_SEL      = 6;
  localparam int SPECTAG_LEN  = 5;
  localparam int FUNCT7_WIDTH = 7;
  localparam int FUNCT3_WIDTH = 3;
  localparam int PASSBITS_LEN = 25;

  typedef struct packed {
    logic                rdy;
    logic [DATA_LEN-1:0] val;
  } operand_t;

  typedef struct packed {
    operand_t                 op1;
    operand_t                 op2;
    logic [DATA_LEN-1:0]      imm;
    logic [RRF_SEL-1:0]       rrftag;
    logic                     dstval;
    logic [FUNCT7_WIDTH-1:0]  funct7;
    logic [FUNCT3_WIDTH-1:0]  funct3;
    logic [PASSBITS_LEN-1:0]  passbits;
    logic [SPECTAG_LEN-1:0]   spectag;
    logic                     specbit;
  } entry_t;

  // A speculative op dies when its branch tag overlaps the mispredicted one.
  function automatic logic spec_hit(input logic specbit,
                                    input logic [SPECTAG_LEN-1:0] tag,
                                    input logic [SPECTAG_LEN-1:0] fix);
    return specbit & (|(tag & fix));
  endfunction

  // Capture a pending operand from the result buses; bus 0 wins a double match.
  function automatic operand_t snoop(input operand_t op,
                                     input logic v0, input logic [RRF_SEL-1:0] t0,
                                     input logic [DATA_LEN-1:0] d0,
                                     input logic v1, input logic [RRF_SEL-1:0] t1,
                                     input logic [DATA_LEN-1:0] d1);
    operand_t r;
    r = op;
    if (!op.rdy) begin
      if (v0 && (t0 == op.val[RRF_SEL-1:0])) begin
        r.rdy = 1'b1;
        r.val = d0;
      end else if (v1 && (t1 == op.val[RRF_SEL-1:0])) begin
        r.rdy = 1'b1;
        r.val = d1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_custom_if.sv
// Dispatch, wakeup, branch-resolution and issue signals of rs_custom.
// master = surrounding pipeline, slave = reservation station.
interface rs_custom_if import rs_custom_pkg::*; #(
  parameter int ENTRY_SEL = 2
) ();
  logic                    dp_we;
  logic [DATA_LEN-1:0]     dp_src1, dp_src2;
  logic                    dp_rdy1, dp_rdy2;
  logic [DATA_LEN-1:0]     dp_imm;
  logic [RRF_SEL-1:0]      dp_rrftag;
  logic                    dp_dstval;
  logic [FUNCT7_WIDTH-1:0] dp_funct7;
  logic [FUNCT3_WIDTH-1:0] dp_funct3;
  logic [PASSBITS_LEN-1:0] dp_passbits;
  logic [SPECTAG_LEN-1:0]  dp_spectag;
  logic                    dp_specbit;
  logic                    wb_val0, wb_val1;
  logic [RRF_SEL-1:0]      wb_tag0, wb_tag1;
  logic [DATA_LEN-1:0]     wb_data0, wb_data1;
  logic                    prmiss, prsuccess;
  logic [SPECTAG_LEN-1:0]  spectagfix;
  logic                    ex_ready;
  logic                    issue;
  logic [DATA_LEN-1:0]     ex_src1, ex_src2, imm;
  logic [RRF_SEL-1:0]      rrftag;
  logic                    dstval;
  logic [FUNCT7_WIDTH-1:0] funct7;
  logic [FUNCT3_WIDTH-1:0] funct3;
  logic [PASSBITS_LEN-1:0] passbits;
  logic [SPECTAG_LEN-1:0]  spectag;
  logic                    specbit;
  logic                    rs_full;
  logic [ENTRY_SEL:0]      rs_count;

  modport master (
    output dp_we, dp_src1, dp_src2, dp_rdy1, dp_rdy2, dp_imm, dp_rrftag, dp_dstval,
           dp_funct7, dp_funct3, dp_passbits, dp_spectag, dp_specbit,
           wb_val0, wb_val1, wb_tag0, wb_tag1, wb_data0, wb_data1,
           prmiss, prsuccess, spectagfix, ex_ready,
    input  issue, ex_src1, ex_src2, imm, rrftag, dstval, funct7, funct3, passbits,
           spectag, specbit, rs_full, rs_count
  );

  modport slave (
    input  dp_we, dp_src1, dp_src2, dp_rdy1, dp_rdy2, dp_imm, dp_rrftag, dp_dstval,
           dp_funct7, dp_funct3, dp_passbits, dp_spectag, dp_specbit,
           wb_val0, wb_val1, wb_tag0, wb_tag1, wb_data0, wb_data1,
           prmiss, prsuccess, spectagfix, ex_ready,
    output issue, ex_src1, ex_src2, imm, rrftag, dstval, funct7, funct3, passbits,
           spectag, specbit, rs_full, rs_count
  );
endinterface

// File: rtl/rs_custom_select.sv
// Combinational issue select for rs_custom.
// RS_CUSTOM_AGE_SELECT_EN: oldest ready entry (smallest age); otherwise lowest index.
module rs_custom_select import rs_custom_pkg::*; #(
  parameter int ENTRY_NUM = 4,
  parameter int ENTRY_SEL = 2
) (
  input  logic [ENTRY_NUM-1:0]                ready,
`ifdef RS_CUSTOM_AGE_SELECT_EN
  input  logic [ENTRY_NUM-1:0][ENTRY_SEL-1:0] age,
`endif
  output logic                                found,
  output logic [ENTRY_SEL-1:0]                sel
);

  // Scan all entries and keep the best ready candidate.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
`ifdef RS_CUSTOM_AGE_SELECT_EN
      if (ready[i] && (!found || (age[i] < age[sel]))) begin
`else
      if (ready[i] && !found) begin
`endif
        found = 1'b1;
        sel   = ENTRY_SEL'(i);
      end
    end
  end

endmodule

// File: rtl/rs_custom.sv
// Reservation station for the custom execution unit: holds dispatched ops,
// snoops the result buses, and issues one ready op per cycle.
// Optional macro RS_CUSTOM_AGE_SELECT_EN enables oldest-first select.
module rs_custom import rs_custom_pkg::*; #(
  parameter int ENTRY_NUM = 4,
  parameter int ENTRY_SEL = 2
) (
  input logic        clk,
  input logic        reset,
  rs_custom_if.slave rs
);

  entry_t                ent [ENTRY_NUM];
  entry_t                dp_entry;
  logic [ENTRY_NUM-1:0]  valid, valid_nxt, ready_vec, kill_vec, leave_vec;
  logic [ENTRY_SEL:0]    count, count_nxt;
  logic                  full, sel_found, issue_int, dp_kill, dp_write, free_hit;
  logic [ENTRY_SEL-1:0]  sel_idx, free_idx;

`ifdef RS_CUSTOM_AGE_SELECT_EN
  logic [ENTRY_NUM-1:0][ENTRY_SEL-1:0] age, age_nxt;
  logic [ENTRY_SEL:0]                  leave_cnt;
`endif

  assign full = (count == (ENTRY_SEL+1)'(ENTRY_NUM));

  // Per-entry readiness and branch-kill status.
  always_comb begin
    ready_vec = '0;
    kill_vec  = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      ready_vec[i] = valid[i] & ent[i].op1.rdy & ent[i].op2.rdy;
      kill_vec[i]  = rs.prmiss & valid[i] & spec_hit(ent[i].specbit, ent[i].spectag, rs.spectagfix);
    end
  end

  rs_custom_select #(
    .ENTRY_NUM (ENTRY_NUM),
    .ENTRY_SEL (ENTRY_SEL)
  ) u_select (
    .ready (ready_vec),
`ifdef RS_CUSTOM_AGE_SELECT_EN
    .age   (age),
`endif
    .found (sel_found),
    .sel   (sel_idx)
  );

  assign issue_int = rs.ex_ready & sel_found & ~kill_vec[sel_idx];

  // Issue payload straight from the selected entry, zeroed when idle.
  always_comb begin
    rs.issue    = issue_int;
    rs.ex_src1  = '0;
    rs.ex_src2  = '0;
    rs.imm      = '0;
    rs.rrftag   = '0;
    rs.dstval   = 1'b0;
    rs.funct7   = '0;
    rs.funct3   = '0;
    rs.passbits = '0;
    rs.spectag  = '0;
    rs.specbit  = 1'b0;
    if (issue_int) begin
      rs.ex_src1  = ent[sel_idx].op1.val;
      rs.ex_src2  = ent[sel_idx].op2.val;
      rs.imm      = ent[sel_idx].imm;
      rs.rrftag   = ent[sel_idx].rrftag;
      rs.dstval   = ent[sel_idx].dstval;
      rs.funct7   = ent[sel_idx].funct7;
      rs.funct3   = ent[sel_idx].funct3;
      rs.passbits = ent[sel_idx].passbits;
      rs.spectag  = ent[sel_idx].spectag;
      rs.specbit  = ent[sel_idx].specbit;
    end
  end

  assign rs.rs_full  = full;
  assign rs.rs_count = count;

  // Lowest free slot, judged on pre-issue valid bits.
  always_comb begin
    free_hit = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      if (!valid[i] && !free_hit) begin
        free_hit = 1'b1;
        free_idx = ENTRY_SEL'(i);
      end
    end
  end

  // Incoming entry with result-bus bypass and same-cycle commit applied.
  always_comb begin
    dp_entry.op1      = snoop('{rdy: rs.dp_rdy1, val: rs.dp_src1}, rs.wb_val0, rs.wb_tag0,
                              rs.wb_data0, rs.wb_val1, rs.wb_tag1, rs.wb_data1);
    dp_entry.op2      = snoop('{rdy: rs.dp_rdy2, val: rs.dp_src2}, rs.wb_val0, rs.wb_tag0,
                              rs.wb_data0, rs.wb_val1, rs.wb_tag1, rs.wb_data1);
    dp_entry.imm      = rs.dp_imm;
    dp_entry.rrftag   = rs.dp_rrftag;
    dp_entry.dstval   = rs.dp_dstval;
    dp_entry.funct7   = rs.dp_funct7;
    dp_entry.funct3   = rs.dp_funct3;
    dp_entry.passbits = rs.dp_passbits;
    dp_entry.spectag  = rs.dp_spectag;
    dp_entry.specbit  = rs.dp_specbit & ~(rs.prsuccess & (rs.dp_spectag == rs.spectagfix));
  end

  assign dp_kill  = rs.prmiss & spec_hit(rs.dp_specbit, rs.dp_spectag, rs.spectagfix);
  assign dp_write = rs.dp_we & ~full & free_hit & ~dp_kill;

  // Next valid vector: drop issued/killed entries, add the dispatched one.
  always_comb begin
    leave_vec = kill_vec;
    if (issue_int) leave_vec[sel_idx] = 1'b1;
    valid_nxt = valid & ~leave_vec;
    if (dp_write) valid_nxt[free_idx] = 1'b1;
    count_nxt = (ENTRY_SEL+1)'($countones(valid_nxt));
  end

  // Occupancy state.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      count <= '0;
    end else begin
      valid <= valid_nxt;
      count <= count_nxt;
    end
  end

  // Entry payload: wakeup capture, commit, then dispatch write.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      ent[i].op1 <= snoop(ent[i].op1, rs.wb_val0, rs.wb_tag0, rs.wb_data0,
                          rs.wb_val1, rs.wb_tag1, rs.wb_data1);
      ent[i].op2 <= snoop(ent[i].op2, rs.wb_val0, rs.wb_tag0, rs.wb_data0,
                          rs.wb_val1, rs.wb_tag1, rs.wb_data1);
      if (rs.prsuccess && (ent[i].spectag == rs.spectagfix)) ent[i].specbit <= 1'b0;
    end
    if (dp_write) ent[free_idx] <= dp_entry;
  end

`ifdef RS_CUSTOM_AGE_SELECT_EN
  // Ages stay a dense 0..n-1 ordering: survivors shift down past departed elders,
  // and a newcomer lands behind everything that remains after this edge.
  always_comb begin
    leave_cnt = (ENTRY_SEL+1)'($countones(leave_vec));
    age_nxt   = age;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      for (int unsigned j = 0; j < ENTRY_NUM; j++) begin
        if (leave_vec[j] && (age[j] < age[i])) age_nxt[i] = age_nxt[i] - 1'b1;
      end
    end
    if (dp_write) age_nxt[free_idx] = ENTRY_SEL'(count - leave_cnt);
  end

  // Age registers.
  always_ff @(posedge clk) begin
    age <= age_nxt;
  end
`endif

endmodule

// File: tb/tb_rs_custom.sv
// Self-checking bench for rs_custom: directed scenarios followed by random
// traffic, checked every cycle against a slot-level reference model.
module tb_rs_custom;
  import rs_custom_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  rs_custom_if #(.ENTRY_SEL(2)) bus ();

  rs_custom #(.ENTRY_NUM(4), .ENTRY_SEL(2)) dut (
    .clk   (clk),
    .reset (reset),
    .rs    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    bit          r1, r2;
    logic [31:0] s1, s2, imm;
    logic [5:0]  tag;
    bit          dst;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [24:0] pb;
    logic [4:0]  st;
    bit          sb;
    int          seq;
  } slot_t;

  slot_t m [4];
  int    seq_ctr = 0;
  int    m_sel;
  bit    m_issue;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 4; i++) if (m[i].v) c++;
    return c;
  endfunction

  // Oldest-first or lowest-index among ops with both operands present.
  function automatic int m_pick();
    int best = -1;
    for (int i = 0; i < 4; i++) begin
      if (m[i].v && m[i].r1 && m[i].r2) begin
`ifdef RS_CUSTOM_AGE_SELECT_EN
        if (best < 0 || m[i].seq < m[best].seq) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  function automatic bit m_killed(input int i);
    return bus.prmiss && m[i].v && m[i].sb && ((m[i].st & bus.spectagfix) != 5'd0);
  endfunction

  task automatic model_check();
    int p, q;
    logic [47:0] misc;
    p = m_pick();
    q = (p < 0) ? 0 : p;
    m_issue = bus.ex_ready && (p >= 0) && !m_killed(q);
    m_sel = q;
    misc = m_issue ? {m[q].tag, m[q].dst, m[q].f7, m[q].f3, m[q].pb, m[q].st, m[q].sb} : 48'd0;
    chk("issue", {63'd0, bus.issue}, {63'd0, m_issue});
    chk("ex_src1", {32'd0, bus.ex_src1}, m_issue ? {32'd0, m[q].s1} : 64'd0);
    chk("ex_src2", {32'd0, bus.ex_src2}, m_issue ? {32'd0, m[q].s2} : 64'd0);
    chk("imm", {32'd0, bus.imm}, m_issue ? {32'd0, m[q].imm} : 64'd0);
    chk("payload", {16'd0, bus.rrftag, bus.dstval, bus.funct7, bus.funct3, bus.passbits,
                    bus.spectag, bus.specbit}, {16'd0, misc});
    chk("rs_count", {61'd0, bus.rs_count}, 64'(m_count()));
    chk("rs_full", {63'd0, bus.rs_full}, {63'd0, (m_count() == 4)});
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    int cnt, fr;
    logic [4:0] fix;
    if (reset) begin
      for (int i = 0; i < 4; i++) m[i].v = 0;
      return;
    end
    fix = bus.spectagfix;
    cnt = m_count();
    fr = -1;
    for (int i = 3; i >= 0; i--) if (!m[i].v) fr = i;
    if (m_issue) m[m_sel].v = 0;
    if (bus.prmiss)
      for (int i = 0; i < 4; i++) if (m[i].sb && ((m[i].st & fix) != 5'd0)) m[i].v = 0;
    for (int i = 0; i < 4; i++) begin
      if (!m[i].r1) begin
        if (bus.wb_val0 && bus.wb_tag0 == m[i].s1[5:0]) begin m[i].s1 = bus.wb_data0; m[i].r1 = 1; end
        else if (bus.wb_val1 && bus.wb_tag1 == m[i].s1[5:0]) begin m[i].s1 = bus.wb_data1; m[i].r1 = 1; end
      end
      if (!m[i].r2) begin
        if (bus.wb_val0 && bus.wb_tag0 == m[i].s2[5:0]) begin m[i].s2 = bus.wb_data0; m[i].r2 = 1; end
        else if (bus.wb_val1 && bus.wb_tag1 == m[i].s2[5:0]) begin m[i].s2 = bus.wb_data1; m[i].r2 = 1; end
      end
      if (bus.prsuccess && m[i].st == fix) m[i].sb = 0;
    end
    if (bus.dp_we && cnt < 4 &&
        !(bus.prmiss && bus.dp_specbit && ((bus.dp_spectag & fix) != 5'd0))) begin
      m[fr].v = 1;
      m[fr].r1 = bus.dp_rdy1;  m[fr].s1 = bus.dp_src1;
      m[fr].r2 = bus.dp_rdy2;  m[fr].s2 = bus.dp_src2;
      if (!m[fr].r1) begin
        if (bus.wb_val0 && bus.wb_tag0 == m[fr].s1[5:0]) begin m[fr].s1 = bus.wb_data0; m[fr].r1 = 1; end
        else if (bus.wb_val1 && bus.wb_tag1 == m[fr].s1[5:0]) begin m[fr].s1 = bus.wb_data1; m[fr].r1 = 1; end
      end
      if (!m[fr].r2) begin
        if (bus.wb_val0 && bus.wb_tag0 == m[fr].s2[5:0]) begin m[fr].s2 = bus.wb_data0; m[fr].r2 = 1; end
        else if (bus.wb_val1 && bus.wb_tag1 == m[fr].s2[5:0]) begin m[fr].s2 = bus.wb_data1; m[fr].r2 = 1; end
      end
      m[fr].imm = bus.dp_imm;   m[fr].tag = bus.dp_rrftag;  m[fr].dst = bus.dp_dstval;
      m[fr].f7 = bus.dp_funct7; m[fr].f3 = bus.dp_funct3;   m[fr].pb = bus.dp_passbits;
      m[fr].st = bus.dp_spectag;
      m[fr].sb = bus.dp_specbit && !(bus.prsuccess && bus.dp_spectag == fix);
      m[fr].seq = seq_ctr++;
    end
  endtask

  task automatic cycle();
    #2;
    model_check();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dp_we = 0;  bus.wb_val0 = 0;  bus.wb_val1 = 0;
    bus.prmiss = 0; bus.prsuccess = 0;
  endtask

  task automatic dispatch(input logic [31:0] s1, input bit r1, input logic [31:0] s2, input bit r2,
                          input logic [4:0] st, input bit sb);
    bus.dp_we = 1;
    bus.dp_src1 = s1;  bus.dp_rdy1 = r1;
    bus.dp_src2 = s2;  bus.dp_rdy2 = r2;
    bus.dp_imm = $urandom;
    bus.dp_rrftag = 6'($urandom);
    bus.dp_dstval = 1'($urandom);
    bus.dp_funct7 = 7'($urandom);
    bus.dp_funct3 = 3'($urandom);
    bus.dp_passbits = 25'($urandom);
    bus.dp_spectag = st;
    bus.dp_specbit = sb;
  endtask

  initial begin
    logic [31:0] r;
    reset = 1;
    bus.ex_ready = 1;
    bus.spectagfix = '0;
    bus.wb_tag0 = '0;  bus.wb_tag1 = '0;
    bus.wb_data0 = '0; bus.wb_data1 = '0;
    dispatch(32'd0, 1, 32'd0, 1, 5'd0, 0);
    idle();
    @(posedge clk);
    #1;
    cycle();
    reset = 0;
    #1;
    chk("rst_issue", {63'd0, bus.issue}, 64'd0);
    chk("rst_count", {61'd0, bus.rs_count}, 64'd0);
    chk("rst_full", {63'd0, bus.rs_full}, 64'd0);
    cycle();

    // Ready dispatch issues the next cycle.
    dispatch(32'h5, 1, 32'h7, 1, 5'b00001, 0);
    cycle();
    idle();
    #1;
    chk("rd_issue", {63'd0, bus.issue}, 64'd1);
    chk("rd_src1", {32'd0, bus.ex_src1}, 64'h5);
    chk("rd_src2", {32'd0, bus.ex_src2}, 64'h7);
    cycle();
    chk("rd_count0", {61'd0, bus.rs_count}, 64'd0);

    // Wakeup on bus 1 two cycles after dispatch.
    dispatch(32'h12, 0, 32'h3, 1, 5'b00001, 0);
    cycle();
    idle();
    cycle();
    bus.wb_val1 = 1; bus.wb_tag1 = 6'h12; bus.wb_data1 = 32'hDEADBEEF;
    #1;
    chk("wk_noissue", {63'd0, bus.issue}, 64'd0);
    cycle();
    idle();
    #1;
    chk("wk_issue", {63'd0, bus.issue}, 64'd1);
    chk("wk_src1", {32'd0, bus.ex_src1}, 64'hDEADBEEF);
    cycle();

    // Fill while stalled, overflow ignored, then drain.
    bus.ex_ready = 0;
    for (int i = 0; i < 4; i++) begin
      dispatch(32'h100 + i, 1, 32'h0, 1, 5'b00001, 0);
      cycle();
    end
    #1;
    chk("full_flag", {63'd0, bus.rs_full}, 64'd1);
    chk("full_count", {61'd0, bus.rs_count}, 64'd4);
    dispatch(32'hBAD, 1, 32'h0, 1, 5'b00001, 0);
    cycle();
    idle();
    bus.ex_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_src1", {32'd0, bus.ex_src1}, 64'h100 + 64'(i));
      cycle();
    end
    #1;
    chk("drain_empty", {63'd0, bus.issue}, 64'd0);
    cycle();

    // Mispredict kills the selected speculative op; only the other issues.
    bus.ex_ready = 0;
    dispatch(32'hA, 1, 32'h0, 1, 5'b00010, 1);
    cycle();
    dispatch(32'hB, 1, 32'h0, 1, 5'b00100, 0);
    cycle();
    idle();
    bus.ex_ready = 1;
    bus.prmiss = 1; bus.spectagfix = 5'b00010;
    #1;
    chk("kill_noissue", {63'd0, bus.issue}, 64'd0);
    cycle();
    idle();
    #1;
    chk("kill_count", {61'd0, bus.rs_count}, 64'd1);
    chk("kill_src1", {32'd0, bus.ex_src1}, 64'hB);
    cycle();

    // Commit clears specbit before issue.
    bus.ex_ready = 0;
    dispatch(32'hC, 1, 32'h0, 1, 5'b01000, 1);
    cycle();
    idle();
    bus.prsuccess = 1; bus.spectagfix = 5'b01000;
    cycle();
    idle();
    bus.ex_ready = 1;
    #1;
    chk("commit_issue", {63'd0, bus.issue}, 64'd1);
    chk("commit_specbit", {63'd0, bus.specbit}, 64'd0);
    cycle();

    // Dispatch-time bypass from bus 0.
    dispatch(32'h1, 1, 32'h3, 0, 5'b00001, 0);
    bus.wb_val0 = 1; bus.wb_tag0 = 6'h03; bus.wb_data0 = 32'h11;
    cycle();
    idle();
    #1;
    chk("byp_issue", {63'd0, bus.issue}, 64'd1);
    chk("byp_src2", {32'd0, bus.ex_src2}, 64'h11);
    cycle();

    // Reset mid-operation discards contents.
    bus.ex_ready = 0;
    dispatch(32'h21, 1, 32'h0, 1, 5'b00001, 0);
    cycle();
    dispatch(32'h22, 1, 32'h0, 1, 5'b00001, 0);
    cycle();
    idle();
    reset = 1;
    cycle();
    reset = 0;
    bus.ex_ready = 1;
    #1;
    chk("mid_rst_count", {61'd0, bus.rs_count}, 64'd0);
    chk("mid_rst_issue", {63'd0, bus.issue}, 64'd0);
    cycle();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      idle();
      reset = ($urandom_range(0, 199) == 0);
      bus.ex_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1) begin
        logic [31:0] a, b;
        bit ra, rb;
        ra = ($urandom_range(0, 2) != 0);
        rb = ($urandom_range(0, 2) != 0);
        a = $urandom; b = $urandom;
        if (!ra) a[5:0] = 6'($urandom_range(0, 7));
        if (!rb) b[5:0] = 6'($urandom_range(0, 7));
        dispatch(a, ra, b, rb, 5'd1 << $urandom_range(0, 4), 1'($urandom));
      end
      bus.wb_val0 = 1'($urandom); bus.wb_tag0 = 6'($urandom_range(0, 7)); bus.wb_data0 = $urandom;
      bus.wb_val1 = 1'($urandom); bus.wb_tag1 = 6'($urandom_range(0, 7)); bus.wb_data1 = $urandom;
      r = $urandom_range(0, 19);
      bus.prmiss = (r == 0);
      bus.prsuccess = (r == 1) || (r == 2);
      bus.spectagfix = 5'd1 << $urandom_range(0, 4);
      cycle();
    end
    reset = 0;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_custom.md
Name: rs_custom

Overview:
- Reservation station that holds decoded custom-logic instructions until their operands are ready, then issues one per cycle to the custom execution unit.
- Sits between the dispatch stage and the custom execution unit.
- Captures operand values from the result buses (wakeup).
- Supplies the unit's issue, operand, immediate, funct and speculation-tag inputs.
- Tracks branch speculation so it can flush or commit entries.

Parameters:
- ENTRY_NUM, 4, number of station entries; must be a power of two.
- ENTRY_SEL, 2, log2(ENTRY_NUM); width of the entry index.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dp_we  in  1  dispatch request: write one instruction this cycle
- dp_src1 / dp_src2  in  `DATA_LEN each  operand value, or the producer RRF tag in the low `RRF_SEL bits when not ready
- dp_rdy1 / dp_rdy2  in  1 each  operand already valid
- dp_imm  in  `DATA_LEN  immediate
- dp_rrftag  in  `RRF_SEL  destination RRF tag
- dp_dstval  in  1  instruction writes a destination
- dp_funct7  in  `FUNCT7_WIDTH
- dp_funct3  in  `FUNCT3_WIDTH
- dp_passbits  in  25
- dp_spectag  in  `SPECTAG_LEN  one-hot branch tag
- dp_specbit  in  1  instruction is speculative
- wb_val0 / wb_val1  in  1 each  result bus valid
- wb_tag0 / wb_tag1  in  `RRF_SEL each  result bus RRF tag
- wb_data0 / wb_data1  in  `DATA_LEN each  result bus data
- prmiss  in  1  branch mispredict resolved
- prsuccess  in  1  branch prediction confirmed
- spectagfix  in  `SPECTAG_LEN  tag of the resolved branch
- ex_ready  in  1  custom unit can accept an instruction this cycle
- issue  out  1  instruction presented to the unit this cycle
- ex_src1 / ex_src2  out  `DATA_LEN each  issued operands
- imm  out  `DATA_LEN  issued immediate
- rrftag  out  `RRF_SEL  issued destination tag
- dstval  out  1
- funct7  out  `FUNCT7_WIDTH
- funct3  out  `FUNCT3_WIDTH
- passbits  out  25
- spectag  out  `SPECTAG_LEN
- specbit  out  1
- rs_full  out  1  no free entry
- rs_count  out  ENTRY_SEL+1  number of valid entries

Behaviour:
- **Reset:**
  - Synchronous reset clears all entry valid bits; a reset mid-operation discards all contents.
  - Afterwards issue=0, rs_full=0, rs_count=0.
  - Issue payload outputs are 0 whenever issue=0.
- **Entry state:** valid, rdy1, rdy2, src1, src2, imm, rrftag, dstval, funct7, funct3, passbits, spectag, specbit. All are registers.
- **Dispatch:**
  - When dp_we=1 and rs_full=0, the lowest-index free entry is written at the clock edge.
  - A dispatch while full is ignored; upstream guarantees it does not happen.
  - Free status is taken from the state before this cycle's issue. A slot freed by issue is reusable the next cycle.
- **Dispatch/wakeup bypass:**
  - Applies when a dispatched operand is not ready and wb_valN=1 with wb_tagN equal to its tag in the same cycle.
  - The entry is written with wb_dataN and the ready bit set.
  - Bus 0 has priority if both buses match.
- **Wakeup:**
  - Each valid, not-ready operand whose tag matches a valid result bus captures the data and sets its ready bit at the edge.
  - The entry is eligible for issue the following cycle.
- **Select and issue:**
  - An entry is ready when valid & rdy1 & rdy2.
  - issue = ex_ready & (any ready entry) & ~killed(selected).
  - Outputs are combinational from the selected entry's registers.
  - On issue the entry's valid bit clears at the edge.
  - Issue latency: 1 cycle from dispatch of a fully ready op, and 1 cycle after the wakeup edge.
  - When ex_ready=0, issue=0 and all entries are held.
- **Mispredict (prmiss):**
  - An entry is killed when specbit & ((spectag & spectagfix)!=0).
  - Killed entries are invalidated at the edge.
  - A killed selected entry is not issued; the same cycle issues nothing.
  - A same-cycle dispatch matching the kill condition is not written.
- **Commit (prsuccess):** entries with spectag==spectagfix get specbit cleared at the edge, including a same-cycle dispatch. prmiss and prsuccess are never asserted together.
- **Status:**
  - rs_count is the registered population count of valid bits.
  - rs_full = (rs_count == ENTRY_NUM).
- **Simultaneous events:** dispatch, wakeup, issue and kill in one cycle are all applied at the same edge without conflict. Issue and dispatch never target the same entry.

Optional Feature:
- Macro RS_CUSTOM_AGE_SELECT_EN.
- Defined:
  - Each entry carries an ENTRY_SEL-bit age counter, set to the current rs_count on dispatch.
  - The counter decrements for each older entry that leaves (issue or kill).
  - Select picks the ready entry with the smallest age, i.e. the oldest-first.
- Undefined: select picks the lowest-index ready entry (fixed priority).

Decomposition:
- Widths DATA_LEN, RRF_SEL, SPECTAG_LEN, FUNCT7_WIDTH and FUNCT3_WIDTH come from the shared constants.vh; no new global constants are added.
- One sub-module, rs_custom_select:
  - Inputs: ready vector and (with the feature) age vectors.
  - Outputs: a found flag and the selected index.
  - It is purely combinational.

Test Plan:
- **Ready dispatch:** dp_we with rdy1=rdy2=1, src1=0x5, src2=0x7, ex_ready=1 -> next cycle issue=1, ex_src1=0x5, ex_src2=0x7; rs_count returns to 0 the cycle after.
- **Wakeup:** dispatch with rdy1=0, tag 0x12; two cycles later wb_val1=1, wb_tag1=0x12, wb_data1=0xDEADBEEF -> issue in the cycle after that wakeup with ex_src1=0xDEADBEEF.
- **Full:** ex_ready=0 with 4 dispatches -> rs_full=1, rs_count=4; a 5th dispatch leaves contents unchanged; raising ex_ready drains one entry per cycle.
- **Mispredict:** dispatch entries with spectag 0b00010 (specbit=1) and 0b00100 (specbit=0), then prmiss with spectagfix=0b00010 -> the first is dropped, rs_count=1, and only the second ever issues.
- **Commit:** dispatch with specbit=1 and spectag 0b01000, then prsuccess with spectagfix=0b01000 -> the later issue shows specbit=0.
- **Bypass:** dispatch with rdy2=0 and tag 0x03 while wb_val0=1, wb_tag0=0x03, wb_data0=0x11 -> issue next cycle with ex_src2=0x11.
